// File: rtl/kgd_fill_if.sv
// Bus bundle for the KGD fill engine: CPU-facing Wishbone slave signals plus
// the Wishbone master port that drives the KGD register window.
interface kgd_fill_if;
  logic [2:0]  wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [1:0]  wb_sel_i;
  logic        wb_ack_o;
  logic [2:0]  m_adr_o;
  logic [15:0] m_dat_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic [1:0]  m_sel_o;
  logic        m_ack_i;
  logic        irq_o;

  // slave: the fill engine itself; master: the CPU and KGD around it
  modport slave (
    input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, m_ack_i,
    output wb_dat_o, wb_ack_o, m_adr_o, m_dat_o, m_cyc_o, m_stb_o, m_we_o,
           m_sel_o, irq_o
  );
  modport master (
    output wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, m_ack_i,
    input  wb_dat_o, wb_ack_o, m_adr_o, m_dat_o, m_cyc_o, m_stb_o, m_we_o,
           m_sel_o, irq_o
  );
endinterface

// File: rtl/kgd_fill.sv
// KGD video-memory fill engine: CPU programs ADDR/CNT/PAT and sets GO, the
// engine then writes the KGD address and data registers one byte at a time.
module kgd_fill #(
  parameter logic [2:0] KGD_ADR_REG = 3'o4,
  parameter logic [2:0] KGD_DAT_REG = 3'o2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  kgd_fill_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADR, S_GAP1, S_DAT, S_GAP2, S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        ie_q, ie_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;
  logic [13:0] addr_q, addr_d;
  logic [13:0] cnt_q, cnt_d;
  logic [7:0]  pat_q, pat_d;
  logic        ack_q, ack_d;
  logic [15:0] rdat_q, rdat_d;
  logic [2:0]  m_adr_q, m_adr_d;
  logic [15:0] m_dat_q, m_dat_d;
  logic        m_stb_q, m_stb_d;
  logic [1:0]  m_sel_q, m_sel_d;
  logic        wr, mack, act;

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_dat_o = rdat_q;
  assign bus.m_adr_o  = m_adr_q;
  assign bus.m_dat_o  = m_dat_q;
  assign bus.m_cyc_o  = m_stb_q;
  assign bus.m_stb_o  = m_stb_q;
  assign bus.m_we_o   = m_stb_q;
  assign bus.m_sel_o  = m_sel_q;
  assign bus.irq_o    = done_q & ie_q;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    ie_d    = ie_q;
    done_d  = done_q;
    abort_d = abort_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    rdat_d  = rdat_q;
    m_adr_d = 3'd0;
    m_dat_d = 16'd0;
    m_sel_d = 2'b00;
    ack_d   = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;
    wr      = ack_d & bus.wb_we_i;
    // an ack only counts against a strobe we actually have out
    mack    = bus.m_ack_i & m_stb_q;

    if (ack_d) begin
      case (bus.wb_adr_i[2:1])
        2'd0:    rdat_d = {8'h00, done_q, ie_q, 5'b00000, busy_q};
        2'd1:    rdat_d = {2'b00, addr_q};
        2'd2:    rdat_d = {2'b00, cnt_q};
        default: rdat_d = {8'h00, pat_q};
      endcase
    end

    if (wr) begin
      case (bus.wb_adr_i[2:1])
        2'd0: if (bus.wb_sel_i[0]) begin
          if (bus.wb_dat_i[7]) done_d = 1'b0;
          ie_d = bus.wb_dat_i[6];
          if (bus.wb_dat_i[1] && busy_q) abort_d = 1'b1;
          if (bus.wb_dat_i[0] && !busy_q) begin
            if (cnt_q != 14'd0) busy_d = 1'b1;
            else                done_d = 1'b1;
          end
        end
        2'd1: if (!busy_q) begin
          if (bus.wb_sel_i[0]) addr_d[7:0]  = bus.wb_dat_i[7:0];
          if (bus.wb_sel_i[1]) addr_d[13:8] = bus.wb_dat_i[13:8];
        end
        2'd2: if (!busy_q) begin
          if (bus.wb_sel_i[0]) cnt_d[7:0]  = bus.wb_dat_i[7:0];
          if (bus.wb_sel_i[1]) cnt_d[13:8] = bus.wb_dat_i[13:8];
        end
        default: if (!busy_q && bus.wb_sel_i[0]) pat_d = bus.wb_dat_i[7:0];
      endcase
    end

    case (state_q)
      S_IDLE: if (busy_q) state_d = S_ADR;
      S_ADR:  if (mack) state_d = S_GAP1;
      S_GAP1: state_d = S_DAT;
      S_DAT:  if (mack) begin
        addr_d  = addr_q + 14'd1;
        cnt_d   = cnt_q - 14'd1;
        state_d = S_GAP2;
      end
      S_GAP2: state_d = (cnt_q == 14'd0 || abort_q) ? S_FIN : S_ADR;
      S_FIN: begin
        // FIN is evaluated after the CPU write so a same-clock DONE clear loses
        done_d  = 1'b1;
        busy_d  = 1'b0;
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // the first ADR after IDLE holds strobe low for a clock (start latency)
    act     = (state_d == S_ADR || state_d == S_DAT) && state_q != S_IDLE;
    m_stb_d = act;
    if (act) begin
      if (state_d == S_ADR) begin
        m_adr_d = KGD_ADR_REG;
        m_dat_d = {2'b00, addr_q};
        m_sel_d = 2'b11;
      end else begin
        m_adr_d = KGD_DAT_REG;
        m_dat_d = {8'h00, pat_q};
        m_sel_d = 2'b01;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      addr_q  <= 14'd0;
      cnt_q   <= 14'd0;
      pat_q   <= 8'd0;
      ack_q   <= 1'b0;
      rdat_q  <= 16'd0;
      m_adr_q <= 3'd0;
      m_dat_q <= 16'd0;
      m_stb_q <= 1'b0;
      m_sel_q <= 2'b00;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      ie_q    <= ie_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      m_adr_q <= m_adr_d;
      m_dat_q <= m_dat_d;
      m_stb_q <= m_stb_d;
      m_sel_q <= m_sel_d;
    end
  end

endmodule
